// File: rtl/tft_rx.sv
// Panel-side RGB/sync receiver: synchronizes the asynchronous video bus into clk,
// strobes active pixels with coordinates, measures geometry and tracks lock.
module tft_rx #(
  parameter int EXP_WIDTH   = 800,
  parameter int EXP_HEIGHT  = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pxclk,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        err_clear,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [11:0] meas_width,
  output logic [11:0] meas_height,
  output logic        err_width,
  output logic        err_height
);
  localparam logic [11:0] W  = 12'(EXP_WIDTH);
  localparam logic [11:0] H  = 12'(EXP_HEIGHT);
  localparam logic [7:0]  LF = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCK} state_t;

  state_t      state;
  logic [27:0] sync1, sync2;
  logic        px_q, hs_q, vs_q, de_q;
  logic [11:0] x, y;
  logic [7:0]  good_cnt;
  logic        wbad;

  logic        px_s, hs_s, vs_s, de_s;
  logic [23:0] rgb_s;
  assign {px_s, hs_s, vs_s, de_s, rgb_s} = sync2;

  // de is only honoured outside the vertical sync pulse
  logic sample, de_act, v_fall, d_fall, h_fall, frame_ok;
  logic [7:0] good_nxt;
  assign sample   = px_s & ~px_q;
  assign de_act   = de_s & vs_s;
  assign v_fall   = vs_q & ~vs_s;
  assign d_fall   = de_q & ~de_act;
  assign h_fall   = hs_q & ~hs_s;
  assign frame_ok = ~wbad & (y == H);
  assign good_nxt = good_cnt + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      sync1       <= '0;
      sync2       <= '0;
      px_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      x           <= '0;
      y           <= '0;
      good_cnt    <= '0;
      wbad        <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
      err_width   <= 1'b0;
      err_height  <= 1'b0;
    end else begin
      sync1       <= {pxclk, hsync, vsync, de, r, g, b};
      sync2       <= sync1;
      px_q        <= px_s;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      // clear is written first so a same-cycle error set overrides it
      if (err_clear) begin
        err_width  <= 1'b0;
        err_height <= 1'b0;
      end
      if (sample) begin
        hs_q <= hs_s;
        vs_q <= vs_s;
        de_q <= de_act;
        if (v_fall) begin
          x    <= '0;
          y    <= '0;
          wbad <= 1'b0;
          if (state == SEARCH) begin
            // the frame in flight when we arrived is partial: no evaluation
            state <= TRACK;
          end else begin
            frame_start <= 1'b1;
            meas_height <= y;
            if (frame_ok) begin
              good_cnt <= (good_nxt >= LF) ? LF : good_nxt;
              if (good_nxt >= LF) begin
                state  <= LOCK;
                locked <= 1'b1;
              end
            end else begin
              if (y != H) err_height <= 1'b1;
              good_cnt <= '0;
              locked   <= 1'b0;
              state    <= TRACK;
            end
          end
        end else if (de_act) begin
          if (x != 12'hFFF) x <= x + 12'd1;
          if (state != SEARCH && x < W && y < H) begin
            pix_valid <= 1'b1;
            pix_x     <= x[9:0];
            pix_y     <= y[8:0];
            pix_rgb   <= rgb_s;
          end
        end else if (d_fall) begin
          x <= '0;
          if (state != SEARCH) begin
            meas_width <= x;
            if (x != W) begin
              err_width <= 1'b1;
              wbad      <= 1'b1;
            end
            if (y != 12'hFFF) y <= y + 12'd1;
          end
        end else if (h_fall) begin
          // line resync guard for a de that never rose this line
          x <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_tft_rx.sv
// Scoreboarded bench for tft_rx on a reduced 8x4 geometry with pxclk = clk/8.
module tb_tft_rx;
  localparam int W = 8;
  localparam int H = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic pxclk = 1'b0, hsync = 1'b1, vsync = 1'b1, de = 1'b0, err_clear = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic        pix_valid, frame_start, locked, err_width, err_height;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [23:0] pix_rgb;
  logic [11:0] meas_width, meas_height;

  tft_rx #(.EXP_WIDTH(W), .EXP_HEIGHT(H), .LOCK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .pxclk(pxclk), .hsync(hsync), .vsync(vsync), .de(de),
    .r(r), .g(g), .b(b), .err_clear(err_clear),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked),
    .meas_width(meas_width), .meas_height(meas_height),
    .err_width(err_width), .err_height(err_height)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, fs_cnt = 0;
  logic [42:0] q[$];
  logic [42:0] exp_e;
  bit on;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // monitor: every strobe must match the oldest expected pixel
  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (pix_valid) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL pix_unexpected x=%0d y=%0d rgb=%h", pix_x, pix_y, pix_rgb);
      end else begin
        exp_e = q.pop_front();
        if ({pix_x, pix_y, pix_rgb} !== exp_e) begin
          failures++;
          $display("FAIL pix got x=%0d y=%0d rgb=%h exp x=%0d y=%0d rgb=%h",
                   pix_x, pix_y, pix_rgb, exp_e[42:33], exp_e[32:24], exp_e[23:0]);
        end
      end
    end
  end

  function automatic logic [23:0] rgb_of(input int x, input int y);
    return {8'(x * 3 + 1), 8'(y * 7 + 2), 8'h5A};
  endfunction

  // one pixel period, entered and left on a clk negedge
  task automatic pix(input logic h, input logic v, input logic d, input logic [23:0] rgb, input bit lat);
    hsync = h; vsync = v; de = d; {r, g, b} = rgb; pxclk = 1'b0;
    repeat (4) @(negedge clk);
    pxclk = 1'b1;
    if (lat) begin
      @(negedge clk); chk("lat_c1", pix_valid, 0);
      @(negedge clk); chk("lat_c2", pix_valid, 0);
      @(negedge clk); chk("lat_c3", pix_valid, 1);
      @(negedge clk);
    end else repeat (4) @(negedge clk);
  endtask

  task automatic line(input logic v, input int wl, input int y, input bit special);
    logic [23:0] c;
    pix(1'b0, v, 1'b0, 24'h0, 1'b0);
    pix(1'b1, v, 1'b0, 24'h0, 1'b0);
    pix(1'b1, v, 1'b0, 24'h0, 1'b0);
    for (int x = 0; x < wl; x++) begin
      c = (special && x == 0) ? 24'h123456 : rgb_of(x, y);
      if (on && x < W && y < H) q.push_back({10'(x), 9'(y), c});
      pix(1'b1, v, 1'b1, c, special && x == 0);
    end
    pix(1'b1, v, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic vphase();
    line(1'b0, 0, 0, 1'b0);
    line(1'b0, 0, 0, 1'b0);
    line(1'b1, 0, 0, 1'b0);
  endtask

  task automatic body(input int nl, input int bad_l, input int bad_w, input bit special, input int rst_l);
    for (int l = 0; l < nl; l++) begin
      if (l == rst_l) begin
        reset = 1'b1;
        #1;
        chk("rst_mid_outs", int'(|{pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked,
                                   meas_width, meas_height, err_width, err_height}), 0);
        on = 1'b0;
        @(negedge clk);
        reset = 1'b0;
      end
      line(1'b1, (l == bad_l) ? bad_w : W, l, special && l == 0);
    end
    line(1'b1, 0, 0, 1'b0);
  endtask

  initial begin
    on = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outs", int'(|{pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked,
                           meas_width, meas_height, err_width, err_height}), 0);
    reset = 1'b0;
    @(negedge clk);
    line(1'b1, 0, 0, 1'b0);                       // idle so the first vsync edge is seen
    // F1: leaves SEARCH, no frame_start, no evaluation
    vphase(); chk("f1_no_fs", fs_cnt, 0); chk("f1_locked", locked, 0);
    body(H, -1, W, 1'b0, -1);
    vphase(); chk("f2_fs", fs_cnt, 1); chk("f2_locked", locked, 0);
    body(H, -1, W, 1'b1, -1);                     // latency/rgb probe at (0,0)
    vphase(); chk("f3_locked", locked, 1); chk("f3_mw", meas_width, W);
    chk("f3_mh", meas_height, H); chk("f3_ew", err_width, 0); chk("f3_eh", err_height, 0);
    body(H, -1, W, 1'b0, -1);
    // short line in a locked stream
    vphase(); chk("f4_locked", locked, 1);
    body(H, 3, W - 1, 1'b0, -1);
    chk("short_mw", meas_width, W - 1); chk("short_ew", err_width, 1); chk("short_lk_hold", locked, 1);
    vphase(); chk("short_unlock", locked, 0);
    body(H, -1, W, 1'b0, -1);
    vphase(); chk("relock_1", locked, 0);
    body(H, -1, W, 1'b0, -1);
    vphase(); chk("relock_2", locked, 1);
    // one extra active line
    body(H + 1, -1, W, 1'b0, -1);
    vphase(); chk("tall_eh", err_height, 1); chk("tall_mh", meas_height, H + 1);
    chk("tall_locked", locked, 0);
    err_clear = 1'b1; @(negedge clk); err_clear = 1'b0; @(negedge clk);
    chk("clr_ew", err_width, 0); chk("clr_eh", err_height, 0);
    // over-wide line: strobes stop at W-1
    body(H, 3, W + 2, 1'b0, -1);
    chk("wide_mw", meas_width, W + 2); chk("wide_ew", err_width, 1); chk("wide_eh", err_height, 0);
    // reset mid-frame, then wait for the next vsync edge
    vphase();
    body(H, -1, W, 1'b0, 2);
    chk("fs_before", fs_cnt, 8);
    on = 1'b1;
    vphase(); chk("post_rst_no_fs", fs_cnt, 8);
    body(H, -1, W, 1'b0, -1);
    vphase(); chk("post_rst_fs", fs_cnt, 9); chk("post_rst_mh", meas_height, H);
    chk("post_rst_locked", locked, 0);
    repeat (8) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
